// File: rtl/fpg8_trace_pkg.sv
// Shared types and constants for the bus trace UART transmitter.
// TRACE_TAG_EN adds the 0xA5 resynchronisation tag byte to every word.
package fpg8_trace_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {TAG, HI, LO} byte_sel_t;

  localparam logic [7:0] TRACE_TAG_BYTE = 8'hA5;
  localparam int BITS_PER_BYTE = 8;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input byte_sel_t sel);
    case (sel)
`ifdef TRACE_TAG_EN
      TAG:     pick_byte = TRACE_TAG_BYTE;
`endif
      HI:      pick_byte = word[15:8];
      default: pick_byte = word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with occupancy count; push while full is honoured only alongside a pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/bus_trace_uart_tx.sv
// Captures 16-bit bus words into a FIFO and sends them as 8N1 UART bytes, HI then LO.
// Define TRACE_TAG_EN to prefix each word with the 0xA5 tag byte.
module bus_trace_uart_tx
  import fpg8_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   bus_in,
  input  logic                          capture,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef TRACE_TAG_EN
  localparam byte_sel_t FIRST_SEL = TAG;
`else
  localparam byte_sel_t FIRST_SEL = HI;
`endif

  tx_state_t         state_q, state_d;
  byte_sel_t         sel_q, sel_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic              push;
  logic              fifo_empty;
  logic [15:0]       fifo_rdata;

  // A capture is accepted when there is room, or when the head leaves at the same edge.
  assign push = capture & (~fifo_full | pop);

  trace_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= HI;
      baud_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx is registered from the next state so the line never glitches on state decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    word_d  = word_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = fifo_rdata;
          sel_d   = FIRST_SEL;
          shift_d = pick_byte(fifo_rdata, FIRST_SEL);
          baud_d  = BAUD_LAST;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (sel_q != LO) begin
`ifdef TRACE_TAG_EN
            sel_d = (sel_q == TAG) ? HI : LO;
`else
            sel_d = LO;
`endif
            shift_d = pick_byte(word_q, sel_d);
            state_d = START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            word_d  = fifo_rdata;
            sel_d   = FIRST_SEL;
            shift_d = pick_byte(fifo_rdata, FIRST_SEL);
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (capture && !push) overflow <= 1'b1;
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bus_trace_uart_tx.sv
// Bench for bus_trace_uart_tx: queue-based line model compared every cycle plus literal frame checks.
// Honours TRACE_TAG_EN to expect the tag byte before each word.
module tb_bus_trace_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef TRACE_TAG_EN
  localparam int BYTES_PER_WORD = 3;
`else
  localparam int BYTES_PER_WORD = 2;
`endif
  localparam int NB    = BYTES_PER_WORD * 10;
  localparam int FRAME = NB * CPB;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        capture = 1'b0;
  logic [15:0] bus_in  = '0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        fifo_full;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  bus_trace_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .capture    (capture),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: words waiting to be sent, plus the expected line value for every remaining cycle of the current frame.
  logic [15:0] model_q[$];
  bit          model_line[$];
  bit          model_ovf = 1'b0;
  bit          model_pop;
  logic [15:0] model_word;

  task automatic appendByte(input logic [7:0] b);
    for (int r = 0; r < CPB; r++) model_line.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < CPB; r++) model_line.push_back(b[i]);
    for (int r = 0; r < CPB; r++) model_line.push_back(1'b1);
  endtask

  task automatic appendWord(input logic [15:0] w);
`ifdef TRACE_TAG_EN
    appendByte(8'hA5);
`endif
    appendByte(w[15:8]);
    appendByte(w[7:0]);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
      model_line.delete();
      model_ovf = 1'b0;
    end else begin
      model_pop = (model_line.size() <= 1) && (model_q.size() > 0);
      if (model_line.size() > 0) void'(model_line.pop_front());
      if (model_pop) begin
        model_word = model_q.pop_front();
        appendWord(model_word);
      end
      if (capture) begin
        if (model_q.size() < DEPTH) model_q.push_back(bus_in);
        else model_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("tx", tx, (model_line.size() > 0) ? model_line[0] : 1'b1);
      checkOutput("busy", busy, model_line.size() > 0);
      checkOutput("fifo_level", fifo_level, model_q.size());
      checkOutput("fifo_full", fifo_full, model_q.size() == DEPTH);
      checkOutput("overflow", overflow, model_ovf);
    end
  end

  task automatic applyStimulus(input logic cap, input logic [15:0] w);
    @(negedge clk);
    capture = cap;
    bus_in  = w;
  endtask

  task automatic pulseReset;
    @(negedge clk);
    capture = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", (busy || fifo_level != 0), 0);
  endtask

  task automatic testLiteralFrame;
    logic [0:NB-1] pat;
    logic [0:NB-1] got;
    logic [15:0]   word;
    int            busy_cnt;
`ifdef TRACE_TAG_EN
    word = 16'h1234;
    pat  = 30'b0_10100101_1_0_01001000_1_0_00101100_1;
`else
    word = 16'h55A3;
    pat  = 20'b0_10101010_1_0_11000101_1;
`endif
    got      = '0;
    busy_cnt = 0;
    applyStimulus(1'b1, word);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("lit_tx_idle_at_capture", tx, 1);
    for (int i = 0; i < FRAME + 8; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 0) checkOutput("lit_tx_fall", tx, 0);
      if (i < FRAME && (i % CPB) == 1) got[i / CPB] = tx;
    end
    checkOutput("lit_line_bits", got, pat);
    checkOutput("lit_busy_cycles", busy_cnt, FRAME);
  endtask

  initial begin
    int busy_cnt;
    int thr;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_full", fifo_full, 0);
    checkOutput("rst_overflow", overflow, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    testLiteralFrame();

    // Back-to-back words: busy must stay high for two full frames.
    applyStimulus(1'b1, 16'h0001);
    applyStimulus(1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0000);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    checkOutput("b2b_busy_cycles", busy_cnt, 2 * FRAME);

    // Six captures from idle: five fit, the sixth is dropped.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'($urandom));
    applyStimulus(1'b0, 16'h0000);
    checkOutput("six_full", fifo_full, 1);
    checkOutput("six_level", fifo_level, 4);
    checkOutput("six_overflow", overflow, 1);
    waitIdle(7 * FRAME);

    // Capture on the edge where the final stop bit pops the next word while full.
    pulseReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'($urandom));
    for (int m = 5; m <= FRAME; m++) applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b1, 16'hBEEF);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("pop_push_level", fifo_level, 4);
    checkOutput("pop_push_full", fifo_full, 1);
    checkOutput("pop_push_overflow", overflow, 0);
    checkOutput("pop_push_tx_start", tx, 0);
    waitIdle(7 * FRAME);

    // Asynchronous reset in the middle of the HI data bits.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'($urandom));
    applyStimulus(1'b0, 16'h0000);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_tx", tx, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_level", fifo_level, 0);
    checkOutput("midrst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 16'($urandom));
    applyStimulus(1'b0, 16'h0000);
    waitIdle(2 * FRAME);

    // Random traffic with varying capture density.
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 3)
        0:       thr = 2;
        1:       thr = 10;
        default: thr = 60;
      endcase
      if (i == 2600) pulseReset();
      applyStimulus($urandom_range(99) < thr, 16'($urandom));
    end
    applyStimulus(1'b0, 16'h0000);
    waitIdle((DEPTH + 2) * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bus_trace_uart_tx.md
Name: bus_trace_uart_tx

Overview:
- Debug transmitter that reads the 16-bit CPU bus and serializes captured words to a host over a UART TX line (8N1).
- Complements the existing bus-drive debug path, which writes values onto the bus. This block reads bus values and sends them off-chip.
- Sits at top level beside the debug register, sharing `one_shot_clock` or `clk`.
- Captured words pass through a small FIFO so the bus side never stalls.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range 2 or more.
- FIFO_DEPTH, 4, number of 16-bit word entries; must be a power of two, 2 or more.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_in  in  16  bus value; sampled only when capture=1.
- capture  in  1  sample bus_in at this edge.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while any frame bit is on tx.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the word being sent.
- fifo_full  out  1  fifo_level == FIFO_DEPTH.
- overflow  out  1  sticky: at least one capture was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, fifo_level=0, fifo_full=0, overflow=0.
  - FSM goes to IDLE, FIFO pointers clear, bit and baud counters clear.
  - Reset in the middle of a frame aborts the frame immediately; tx goes high with no stop bit emitted.
- Capture:
  - capture=1 at edge k pushes bus_in if the FIFO is not full, or if a pop occurs at the same edge k.
  - Otherwise the word is dropped and overflow becomes 1. overflow clears only on reset.
- FSM states: IDLE, START, DATA, STOP. A byte counter selects HI or LO byte.
  - IDLE:
    - If the FIFO is non-empty: pop the head into a 16-bit shift word, select HI, enter START, drive tx=0.
    - In IDLE, a word written at edge k is popped at edge k+1, so tx falls one cycle after the capture edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA:
    - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
    - HI byte = word[15:8], LO byte = word[7:0].
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - After HI: select LO and go to START.
    - After LO: if the FIFO is non-empty, pop at the final STOP cycle and go to START with no idle gap; otherwise go to IDLE.
- A word frame is 20*CLKS_PER_BIT cycles.
- busy=1 in START, DATA and STOP, and 0 in IDLE.
- Push and pop at the same edge while full: both are honoured, and fifo_level is unchanged.
- Push and pop at the same edge while empty cannot occur, since a pop requires non-empty.
- FIFO pointers wrap modulo FIFO_DEPTH. The level counter saturates neither up nor down, because full/empty gating prevents it.
- The baud counter counts CLKS_PER_BIT-1 down to 0. A bit advances when the counter reads 0.

Optional Feature:
- Macro: TRACE_TAG_EN.
- When defined:
  - Each word is preceded by a tag byte 0xA5, giving byte order TAG, HI, LO.
  - The byte counter has 3 values, and a word frame is 30*CLKS_PER_BIT cycles.
  - The host uses the tag for resynchronization.
- When undefined: 2 bytes per word, as above, and no tag logic is synthesized.

Decomposition:
- Package fpg8_trace_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP);
  - byte-select enum (TAG, HI, LO);
  - TRACE_TAG_BYTE = 8'hA5;
  - BITS_PER_BYTE = 8.
- Sub-module trace_fifo: synchronous FIFO with parameters width and depth, ports push/pop/full/empty/level, and asynchronous active-low reset. The top instantiates it once.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, macro off unless noted):
1. Capture 16'h55A3 from IDLE:
   - tx falls 1 cycle after the capture edge.
   - Line sequence is 0, bits of 0x55 LSB-first (1,0,1,0,1,0,1,0), 1, then 0, bits of 0xA3 (1,1,0,0,0,1,0,1), 1.
   - busy stays high for exactly 80 cycles.
2. Capture 16'h0001 and 16'hFFFF on consecutive cycles: the two word frames are back-to-back with no idle cycle, and tx returns high after 160 cycles.
3. Capture 6 words on consecutive cycles starting from IDLE:
   - Words 1–5 are accepted (one sending plus 4 queued) and fifo_full=1.
   - Word 6 is dropped and overflow=1.
   - Exactly 5 words are transmitted in order.
4. While full, capture on the exact edge of the final-STOP pop: the push is accepted, fifo_level stays 4, and overflow stays 0.
5. Assert reset mid-DATA of the HI byte: tx=1 within the same cycle (asynchronous), with busy=0, fifo_level=0 and overflow=0. A new capture after release transmits correctly.
6. With TRACE_TAG_EN defined, capture 16'h1234: the bytes A5, 12, 34 are sent, and busy is high for 120 cycles.
